// File: rtl/xge_init_pkg.sv
// Shared types for the xge_mac bring-up sequencer.
//   init_state_e : sequencer FSM states
//   init_err_e   : error codes reported on err_code
//   idx_width()  : width of an index into n items, never zero
// Macro XGE_INIT_INT_WAIT_EN adds the INT_WAIT state.
package xge_init_pkg;

    typedef enum logic [2:0] {
        StRstHold = 3'd0,
        StIdle    = 3'd1,
        StIssue   = 3'd2,
        StWaitAck = 3'd3,
        StGap     = 3'd4,
`ifdef XGE_INIT_INT_WAIT_EN
        StIntWait = 3'd5,
`endif
        StDone    = 3'd6,
        StErr     = 3'd7
    } init_state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ACK_TO      = 2'd1,
        RD_MISMATCH = 2'd2,
        INT_TO      = 2'd3
    } init_err_e;

    // Bits needed to hold 0..n-1; at least one so n == 1 still gives a legal vector.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xge_rst_stretch.sv
// Reset stretcher: output asserts asynchronously with rst_i and releases after
// HOLD_CYC clock edges have been counted with rst_i low.
//   clk_i     : clock
//   rst_i     : asynchronous active-high reset
//   rst_n_o   : stretched reset, active-low
//   release_o : high in the cycle whose closing edge releases rst_n_o
module xge_rst_stretch
    import xge_init_pkg::*;
#(
    parameter int unsigned HOLD_CYC = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic rst_n_o,
    output logic release_o
);

    localparam int unsigned CNT_W = idx_width(HOLD_CYC);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rel_q, rel_d;

    always_comb begin
        cnt_d     = cnt_q;
        rel_d     = rel_q;
        release_o = 1'b0;
        if (!rel_q) begin
            if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
                rel_d     = 1'b1;
                release_o = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            rel_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            rel_q <= rel_d;
        end
    end

    assign rst_n_o = rel_q;

endmodule

// File: rtl/xge_wb_init_seq.sv
// Bring-up sequencer for xge_mac: holds the three core resets for RST_HOLD_CYC
// cycles after wb_rst_i, then on start replays a Wishbone command table
// (writes, and reads checked against data under a mask).
//   wb_clk_i/wb_rst_i     : clock, async active-high reset
//   start                 : pulse, accepted in IDLE/DONE/ERR only
//   cmd_addr/data/mask/we : packed command table, entry i at [i*W +: W]
//   reset_*_n             : core resets, active-low, released together
//   wb_*                  : Wishbone master port; wb_int_i is the core interrupt
//   busy/done/err_code/err_idx/rd_last : status
// Macro XGE_INIT_INT_WAIT_EN: wait for wb_int_i after the last entry.
module xge_wb_init_seq
    import xge_init_pkg::*;
#(
    parameter int unsigned NUM_CMDS     = 8,
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned RST_HOLD_CYC = 16,
    parameter int unsigned ACK_TIMEOUT  = 64
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_i,
    input  logic                         start,
    input  logic [NUM_CMDS*ADDR_W-1:0]   cmd_addr,
    input  logic [NUM_CMDS*DATA_W-1:0]   cmd_data,
    input  logic [NUM_CMDS*DATA_W-1:0]   cmd_mask,
    input  logic [NUM_CMDS-1:0]          cmd_we,
    output logic                         reset_156m25_n,
    output logic                         reset_xgmii_rx_n,
    output logic                         reset_xgmii_tx_n,
    output logic [ADDR_W-1:0]            wb_adr_o,
    output logic [DATA_W-1:0]            wb_dat_o,
    output logic                         wb_we_o,
    output logic                         wb_cyc_o,
    output logic                         wb_stb_o,
    input  logic                         wb_ack_i,
    input  logic [DATA_W-1:0]            wb_dat_i,
    input  logic                         wb_int_i,
    output logic                         busy,
    output logic                         done,
    output logic [1:0]                   err_code,
    output logic [idx_width(NUM_CMDS)-1:0] err_idx,
    output logic [DATA_W-1:0]            rd_last
);

    localparam int unsigned IDX_W = idx_width(NUM_CMDS);
    localparam int unsigned TMO_W = idx_width(ACK_TIMEOUT);

    init_state_e       state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    init_err_e         err_q, err_d;
    logic [IDX_W-1:0]  err_idx_q, err_idx_d;
    logic [DATA_W-1:0] rd_last_q, rd_last_d;

    logic              core_rst_n;
    logic              rst_release;

    xge_rst_stretch #(
        .HOLD_CYC (RST_HOLD_CYC)
    ) u_rst_stretch (
        .clk_i     (wb_clk_i),
        .rst_i     (wb_rst_i),
        .rst_n_o   (core_rst_n),
        .release_o (rst_release)
    );

    assign reset_156m25_n   = core_rst_n;
    assign reset_xgmii_rx_n = core_rst_n;
    assign reset_xgmii_tx_n = core_rst_n;

    // Current table entry
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_data;
    logic [DATA_W-1:0] cur_mask;
    logic              cur_we;
    logic              cur_last;
    logic              rd_bad;
    logic              tmo_hit;

    assign cur_addr = cmd_addr[idx_q*ADDR_W +: ADDR_W];
    assign cur_data = cmd_data[idx_q*DATA_W +: DATA_W];
    assign cur_mask = cmd_mask[idx_q*DATA_W +: DATA_W];
    assign cur_we   = cmd_we[idx_q];
    assign cur_last = (idx_q == IDX_W'(NUM_CMDS - 1));
    assign rd_bad   = !cur_we && (|((wb_dat_i ^ cur_data) & cur_mask));
    // tmo_q counts cycles already waited, so a hit means this is the last permitted cycle
    assign tmo_hit  = (tmo_q == TMO_W'(ACK_TIMEOUT - 1));

`ifndef XGE_INIT_INT_WAIT_EN
    logic unused_int;
    assign unused_int = wb_int_i;
`endif

    // State register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= StRstHold;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRstHold: if (rst_release) state_d = StIdle;
            StIdle, StDone, StErr: if (start) state_d = StIssue;
            StIssue, StWaitAck: begin
                if (wb_ack_i) begin
                    if (rd_bad) begin
                        state_d = StErr;
                    end else if (cur_last) begin
`ifdef XGE_INIT_INT_WAIT_EN
                        state_d = StIntWait;
`else
                        state_d = StDone;
`endif
                    end else begin
                        state_d = StGap;
                    end
                end else if (tmo_hit) begin
                    state_d = StErr;
                end else begin
                    state_d = StWaitAck;
                end
            end
            StGap: state_d = StIssue;
`ifdef XGE_INIT_INT_WAIT_EN
            StIntWait: begin
                if (wb_int_i) begin
                    state_d = StDone;
                end else if (tmo_hit) begin
                    state_d = StErr;
                end
            end
`endif
            default: state_d = StRstHold;
        endcase
    end

    // Outputs decoded from state; cyc/stb fall asynchronously with wb_rst_i
    always_comb begin
        wb_cyc_o = 1'b0;
        wb_stb_o = 1'b0;
        wb_we_o  = 1'b0;
        wb_adr_o = '0;
        wb_dat_o = '0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            StIssue, StWaitAck: begin
                wb_cyc_o = 1'b1;
                wb_stb_o = 1'b1;
                wb_we_o  = cur_we;
                wb_adr_o = cur_addr;
                wb_dat_o = cur_we ? cur_data : '0;
                busy     = 1'b1;
            end
            StGap: busy = 1'b1;
`ifdef XGE_INIT_INT_WAIT_EN
            StIntWait: busy = 1'b1;
`endif
            StDone: done = 1'b1;
            default: ;
        endcase
    end

    // Entry index, timeout counter and status registers
    always_comb begin
        idx_d     = idx_q;
        tmo_d     = tmo_q;
        err_d     = err_q;
        err_idx_d = err_idx_q;
        rd_last_d = rd_last_q;
        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    idx_d     = '0;
                    tmo_d     = '0;
                    err_d     = ERR_NONE;
                    err_idx_d = '0;
                end
            end
            StIssue, StWaitAck: begin
                if (wb_ack_i) begin
                    tmo_d = '0;
                    if (!cur_we) rd_last_d = wb_dat_i;
                    if (rd_bad) begin
                        err_d     = RD_MISMATCH;
                        err_idx_d = idx_q;
                    end else if (!cur_last) begin
                        // Index stays on the last entry; it returns to 0 only on restart
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else if (tmo_hit) begin
                    err_d     = ACK_TO;
                    err_idx_d = idx_q;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
`ifdef XGE_INIT_INT_WAIT_EN
            StIntWait: begin
                if (!wb_int_i) begin
                    if (tmo_hit) begin
                        err_d     = INT_TO;
                        err_idx_d = IDX_W'(NUM_CMDS - 1);
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            idx_q     <= '0;
            tmo_q     <= '0;
            err_q     <= ERR_NONE;
            err_idx_q <= '0;
            rd_last_q <= '0;
        end else begin
            idx_q     <= idx_d;
            tmo_q     <= tmo_d;
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
            rd_last_q <= rd_last_d;
        end
    end

    assign err_code = err_q;
    assign err_idx  = err_idx_q;
    assign rd_last  = rd_last_q;

endmodule
